// File: rtl/sdram_cmd_arbiter.sv
// Round-robin arbiter feeding the SDRAM command FIFO; read tags are queued so
// returned read data is steered back to the requester that issued the read.
module sdram_cmd_arbiter #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_PORTS-1:0]    req_valid,
  output logic [NUM_PORTS-1:0]    req_ready,
  input  logic [NUM_PORTS-1:0]    req_wr_n,
  input  logic [25*NUM_PORTS-1:0] req_addr,
  input  logic [4*NUM_PORTS-1:0]  req_be,
  input  logic [32*NUM_PORTS-1:0] req_wdata,
  input  logic                    fifo_full,
  output logic                    fifo_wr,
  output logic [61:0]             fifo_wr_data,
  input  logic                    ctl_rdata_valid,
  input  logic [31:0]             ctl_rdata,
  output logic [NUM_PORTS-1:0]    rsp_valid,
  output logic [31:0]             rsp_data,
  output logic                    orphan_err
);

  localparam int unsigned PORT_W = 2;
  localparam int unsigned PTR_W  = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic        wr_n;
    logic [24:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } cmd_word_t;

  logic [PORT_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PORT_W-1:0]    tag_mem_q [TAG_DEPTH];
  logic [PORT_W-1:0]    tag_mem_d [TAG_DEPTH];
  logic [PTR_W-1:0]     tag_rd_q, tag_rd_d;
  logic [PTR_W-1:0]     tag_wr_q, tag_wr_d;
  logic [CNT_W-1:0]     tag_cnt_q, tag_cnt_d;
  logic [NUM_PORTS-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
  logic                 orphan_q, orphan_d;

  logic [NUM_PORTS-1:0] elig;
  logic                 grant_found;
  logic [PORT_W-1:0]    grant_idx;
  cmd_word_t            sel_cmd;
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 tag_room;
  logic [PORT_W-1:0]    tag_head;

  assign pop      = ctl_rdata_valid && (tag_cnt_q != '0);
  // A pop in the same cycle frees a slot, so a read may still issue when full.
  assign tag_room = (tag_cnt_q != CNT_W'(TAG_DEPTH)) || pop;
  assign tag_head = tag_mem_q[tag_rd_q];

  // Eligibility and round-robin grant: search upward from rr_ptr, then wrap.
  always_comb begin
    elig        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      elig[p] = req_valid[p] && (!req_wr_n[p] || tag_room);
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (!grant_found && elig[p] && (PORT_W'(p) >= rr_ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = PORT_W'(p);
      end
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (!grant_found && elig[p]) begin
        grant_found = 1'b1;
        grant_idx   = PORT_W'(p);
      end
    end
  end

  // Granted port's command fields and the issue handshake.
  always_comb begin
    sel_cmd   = '0;
    req_ready = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (PORT_W'(p) == grant_idx) begin
        sel_cmd.wr_n = req_wr_n[p];
        sel_cmd.addr = req_addr[25*p +: 25];
        sel_cmd.be   = req_be[4*p +: 4];
        sel_cmd.data = req_wdata[32*p +: 32];
      end
    end
    issue = reset_n && grant_found && !fifo_full;
    push  = issue && sel_cmd.wr_n;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      req_ready[p] = issue && (PORT_W'(p) == grant_idx);
    end
    fifo_wr      = issue;
    fifo_wr_data = issue ? sel_cmd : '0;
  end

  // Next-state for pointer, tag FIFO and read-return registers.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    tag_mem_d   = tag_mem_q;
    tag_rd_d    = tag_rd_q;
    tag_wr_d    = tag_wr_q;
    tag_cnt_d   = tag_cnt_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    orphan_d    = orphan_q;

    if (issue) begin
      rr_ptr_d = (grant_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_idx + PORT_W'(1);
    end
    if (push) begin
      tag_mem_d[tag_wr_q] = grant_idx;
      tag_wr_d            = tag_wr_q + PTR_W'(1);
    end
    if (pop) begin
      tag_rd_d   = tag_rd_q + PTR_W'(1);
      rsp_data_d = ctl_rdata;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        rsp_valid_d[p] = (tag_head == PORT_W'(p));
      end
    end
    if (push && !pop) begin
      tag_cnt_d = tag_cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      tag_cnt_d = tag_cnt_q - CNT_W'(1);
    end
    if (ctl_rdata_valid && (tag_cnt_q == '0)) begin
      orphan_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      tag_rd_q    <= '0;
      tag_wr_q    <= '0;
      tag_cnt_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      orphan_q    <= 1'b0;
      for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      tag_rd_q    <= tag_rd_d;
      tag_wr_q    <= tag_wr_d;
      tag_cnt_q   <= tag_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      orphan_q    <= orphan_d;
      for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= tag_mem_d[i];
      end
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign orphan_err = orphan_q;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter: round-robin, backpressure, read
// steering, tag-full, orphan and mid-stream reset scenarios.
module tb_sdram_cmd_arbiter;

  localparam int unsigned NP = 2;
  localparam int unsigned TD = 8;

  logic            clk;
  logic            reset_n;
  logic [NP-1:0]   req_valid;
  logic [NP-1:0]   req_ready;
  logic [NP-1:0]   req_wr_n;
  logic [25*NP-1:0] req_addr;
  logic [4*NP-1:0] req_be;
  logic [32*NP-1:0] req_wdata;
  logic            fifo_full;
  logic            fifo_wr;
  logic [61:0]     fifo_wr_data;
  logic            ctl_rdata_valid;
  logic [31:0]     ctl_rdata;
  logic [NP-1:0]   rsp_valid;
  logic [31:0]     rsp_data;
  logic            orphan_err;

  int n_checks = 0;
  int n_errors = 0;

  sdram_cmd_arbiter #(.NUM_PORTS(NP), .TAG_DEPTH(TD)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_wr_n        (req_wr_n),
    .req_addr        (req_addr),
    .req_be          (req_be),
    .req_wdata       (req_wdata),
    .fifo_full       (fifo_full),
    .fifo_wr         (fifo_wr),
    .fifo_wr_data    (fifo_wr_data),
    .ctl_rdata_valid (ctl_rdata_valid),
    .ctl_rdata       (ctl_rdata),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .orphan_err      (orphan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic wr_n, input logic [24:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    req_valid[p]          = v;
    req_wr_n[p]           = wr_n;
    req_addr[25*p +: 25]  = a;
    req_be[4*p +: 4]      = be;
    req_wdata[32*p +: 32] = d;
  endtask

  function automatic logic [61:0] cmd(input logic wr_n, input logic [24:0] a,
                                      input logic [3:0] be, input logic [31:0] d);
    return {wr_n, a, be, d};
  endfunction

  initial begin
    reset_n         = 1'b0;
    req_valid       = '0;
    req_wr_n        = '0;
    req_addr        = '0;
    req_be          = '0;
    req_wdata       = '0;
    fifo_full       = 1'b0;
    ctl_rdata_valid = 1'b0;
    ctl_rdata       = '0;
    step();
    step();
    settle();
    check("rst_fifo_wr",   64'(fifo_wr),      64'd0);
    check("rst_req_ready", 64'(req_ready),    64'd0);
    check("rst_wr_data",   64'(fifo_wr_data), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid),    64'd0);
    check("rst_rsp_data",  64'(rsp_data),     64'd0);
    check("rst_orphan",    64'(orphan_err),   64'd0);

    // Round-robin with continuous writes from both ports.
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 1'b0, 25'h0000001, 4'hF, 32'hA5A5_0000 + 32'(k));
      drive(1, 1'b1, 1'b0, 25'h1FFFFFF, 4'h3, 32'h5A5A_FF00 + 32'(k));
      settle();
      check("rr_fifo_wr", 64'(fifo_wr), 64'd1);
      if (k % 2 == 0) begin
        check("rr_ready_p0", 64'(req_ready), 64'd1);
        check("rr_data_p0", 64'(fifo_wr_data), 64'(cmd(1'b0, 25'h0000001, 4'hF, 32'hA5A5_0000 + 32'(k))));
      end else begin
        check("rr_ready_p1", 64'(req_ready), 64'd2);
        check("rr_data_p1", 64'(fifo_wr_data), 64'(cmd(1'b0, 25'h1FFFFFF, 4'h3, 32'h5A5A_FF00 + 32'(k))));
      end
      step();
    end

    // Port 0 alone issues, leaving rr_ptr at 1.
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    settle();
    check("solo_p0_ready", 64'(req_ready), 64'd1);
    step();

    // Backpressure on port 1.
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b1, 1'b0, 25'h0ABCDE, 4'h9, 32'hDEAD_BEEF);
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("bp_fifo_wr", 64'(fifo_wr),      64'd0);
      check("bp_ready",   64'(req_ready),    64'd0);
      check("bp_wr_data", 64'(fifo_wr_data), 64'd0);
      step();
    end
    fifo_full = 1'b0;
    settle();
    check("bp_release_ready", 64'(req_ready), 64'd2);
    check("bp_release_data", 64'(fifo_wr_data), 64'(cmd(1'b0, 25'h0ABCDE, 4'h9, 32'hDEAD_BEEF)));
    step();
    drive(0, 1'b1, 1'b0, 25'h000123, 4'h1, 32'h0000_0123);
    settle();
    check("bp_after_ptr", 64'(req_ready), 64'd1);
    step();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);

    // Read steering: p0 A, p1 B, p0 C.
    drive(0, 1'b1, 1'b1, 25'h00000A, 4'hF, 32'h0);
    settle();
    check("rd_a_ready", 64'(req_ready), 64'd1);
    check("rd_a_word", 64'(fifo_wr_data), 64'(cmd(1'b1, 25'h00000A, 4'hF, 32'h0)));
    step();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b1, 1'b1, 25'h00000B, 4'hF, 32'h0);
    settle();
    check("rd_b_ready", 64'(req_ready), 64'd2);
    step();
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    drive(0, 1'b1, 1'b1, 25'h00000C, 4'hF, 32'h0);
    settle();
    check("rd_c_ready", 64'(req_ready), 64'd1);
    step();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    ctl_rdata_valid = 1'b1;
    ctl_rdata       = 32'h11;
    settle();
    check("ret_none_yet", 64'(rsp_valid), 64'd0);
    step();
    ctl_rdata = 32'h22;
    settle();
    check("ret1_valid", 64'(rsp_valid), 64'd1);
    check("ret1_data",  64'(rsp_data),  64'h11);
    step();
    ctl_rdata = 32'h33;
    settle();
    check("ret2_valid", 64'(rsp_valid), 64'd2);
    check("ret2_data",  64'(rsp_data),  64'h22);
    step();
    ctl_rdata_valid = 1'b0;
    settle();
    check("ret3_valid", 64'(rsp_valid), 64'd1);
    check("ret3_data",  64'(rsp_data),  64'h33);
    step();
    check("ret_pulse_end", 64'(rsp_valid), 64'd0);

    // Fill the tag FIFO with eight port-0 reads.
    drive(0, 1'b1, 1'b1, 25'h000100, 4'hF, 32'h0);
    for (int k = 0; k < 8; k++) begin
      settle();
      check("fill_issue", 64'(req_ready), 64'd1);
      step();
    end
    drive(1, 1'b1, 1'b0, 25'h000200, 4'hC, 32'hCAFE_0001);
    settle();
    check("full_write_only", 64'(req_ready), 64'd2);
    step();
    settle();
    check("full_write_again", 64'(req_ready), 64'd2);
    step();
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    settle();
    check("full_read_blocked", 64'(fifo_wr), 64'd0);
    ctl_rdata_valid = 1'b1;
    ctl_rdata       = 32'h44;
    settle();
    check("full_pop_push_ready", 64'(req_ready), 64'd1);
    check("full_pop_push_wr",    64'(fifo_wr),   64'd1);
    step();
    ctl_rdata_valid = 1'b0;
    settle();
    check("full_pop_rsp", 64'(rsp_valid), 64'd1);
    check("full_pop_data", 64'(rsp_data), 64'h44);
    check("full_cnt_stays", 64'(fifo_wr), 64'd0);
    drive(0, 1'b0, 1'b0, '0, '0, '0);

    // Drain all eight tags.
    for (int k = 0; k < 8; k++) begin
      ctl_rdata_valid = 1'b1;
      ctl_rdata       = 32'h100 + 32'(k);
      step();
      check("drain_valid", 64'(rsp_valid), 64'd1);
      check("drain_data",  64'(rsp_data),  64'h100 + 64'(k));
    end
    ctl_rdata_valid = 1'b0;
    step();
    check("drain_done", 64'(rsp_valid), 64'd0);

    // Orphan read data.
    check("orphan_clear", 64'(orphan_err), 64'd0);
    ctl_rdata_valid = 1'b1;
    ctl_rdata       = 32'h55;
    step();
    ctl_rdata_valid = 1'b0;
    settle();
    check("orphan_set",    64'(orphan_err), 64'd1);
    check("orphan_no_rsp", 64'(rsp_valid),  64'd0);
    step();
    step();
    check("orphan_sticky", 64'(orphan_err), 64'd1);

    // Reset with three reads outstanding.
    drive(0, 1'b1, 1'b1, 25'h000300, 4'hF, 32'h0);
    for (int k = 0; k < 3; k++) begin
      settle();
      check("pre_rst_issue", 64'(req_ready), 64'd1);
      step();
    end
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    reset_n = 1'b0;
    step();
    check("mid_rst_rsp_valid", 64'(rsp_valid),    64'd0);
    check("mid_rst_rsp_data",  64'(rsp_data),     64'd0);
    check("mid_rst_orphan",    64'(orphan_err),   64'd0);
    check("mid_rst_fifo_wr",   64'(fifo_wr),      64'd0);
    check("mid_rst_wr_data",   64'(fifo_wr_data), 64'd0);
    reset_n         = 1'b1;
    ctl_rdata_valid = 1'b1;
    ctl_rdata       = 32'h66;
    step();
    ctl_rdata_valid = 1'b0;
    settle();
    check("post_rst_orphan", 64'(orphan_err), 64'd1);
    check("post_rst_no_rsp", 64'(rsp_valid),  64'd0);
    drive(0, 1'b1, 1'b0, 25'h000001, 4'h1, 32'h1);
    drive(1, 1'b1, 1'b0, 25'h000002, 4'h2, 32'h2);
    settle();
    check("post_rst_ptr0", 64'(req_ready), 64'd1);
    step();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_arbiter.md
# sdram_cmd_arbiter

Round-robin arbiter that shares the SDRAM controller's 2-entry command input FIFO among up to four requesters. Packs each granted request into the 62-bit FIFO command word. Tracks outstanding reads in an internal tag FIFO so read data returned by the controller is steered back to the requester that issued the read. Sits directly upstream of the command FIFO's write port and alongside the controller's read-data output.

## Interface
- NUM_PORTS, 2, number of requesters (2..4)
- TAG_DEPTH, 8, maximum outstanding reads (power of two, 2..16)
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  NUM_PORTS  per-port request valid
- req_ready  out  NUM_PORTS  per-port accept; a request transfers when valid & ready
- req_wr_n  in  NUM_PORTS  1 = read, 0 = write
- req_addr  in  25*NUM_PORTS  word address, port p at [25p+24:25p]
- req_be  in  4*NUM_PORTS  byte enables, port p at [4p+3:4p]
- req_wdata  in  32*NUM_PORTS  write data, port p at [32p+31:32p]
- fifo_full  in  1  command FIFO full flag
- fifo_wr  out  1  command FIFO write strobe
- fifo_wr_data  out  62  {wr_n[61], addr[60:36], be[35:32], data[31:0]}
- ctl_rdata_valid  in  1  controller read-data strobe, in issue order
- ctl_rdata  in  32  controller read data
- rsp_valid  out  NUM_PORTS  one-hot read-return strobe, no backpressure
- rsp_data  out  32  read data, shared by all ports
- orphan_err  out  1  sticky: read data arrived with no outstanding tag

## Operation
- Eligible port: req_valid=1 and (req_wr_n=0 or tag FIFO not full).
- Grant: first eligible port at or after rr_ptr, searching upward with wrap from NUM_PORTS-1 to 0. Purely combinational.
- Issue: fifo_wr = (any eligible) & !fifo_full.
  - req_ready is one-hot on the granted port when fifo_wr=1; all zero otherwise.
  - fifo_wr_data is the granted port's fields.
  - fifo_wr_data = 0 when fifo_wr=0.
- On each issue: rr_ptr <= granted+1, wrapping to 0 past NUM_PORTS-1. rr_ptr holds when nothing is issued.
- Read issue pushes the granted port index (2 bits) into the tag FIFO. Writes push nothing.
- Tag FIFO: circular buffer with rd/wr pointers and a count of 0..TAG_DEPTH.
  - Full: count==TAG_DEPTH. Reads from every port become ineligible; writes continue.
  - Simultaneous push and pop: count unchanged, both pointers advance. This is legal when the FIFO is full, since the pop frees a slot in the same cycle.
- Read return: ctl_rdata_valid=1 with count>0 pops the head tag.
  - The following cycle: rsp_valid[tag]=1 and rsp_data=ctl_rdata (registered).
- Orphan: ctl_rdata_valid=1 with count==0 sets orphan_err. The FIFO is not popped and no rsp_valid is raised. orphan_err clears only on reset.
- No lock or burst: consecutive requests from one port interleave with other ports under round-robin.

## Timing
- Reset values: req_ready=0, fifo_wr=0, fifo_wr_data=0, rsp_valid=0, rsp_data=0, orphan_err=0, rr_ptr=0, tag count=0, tag pointers=0.
- Request-to-FIFO latency is 0 cycles; fifo_wr is combinational from req_valid, fifo_full and internal state.
- fifo_wr is never asserted while fifo_full=1.
- Read-return latency is 1 cycle from ctl_rdata_valid to rsp_valid.
- rsp_valid is a single-cycle pulse. Back-to-back ctl_rdata_valid gives back-to-back rsp_valid.
- Sustained throughput is one command per cycle while the FIFO has space.
- Reset mid-operation discards all outstanding tags. Read data arriving after reset raises orphan_err.
- Requesters may drop req_valid without having been accepted.

## Test plan
- Round-robin fairness: NUM_PORTS=2, both ports issue continuous writes, fifo_full=0 → grants alternate 0,1,0,1… starting with port 0 after reset; fifo_wr_data[61]=0 throughout; addr/be/data match the granted port.
- Backpressure: fifo_full=1 for 3 cycles with port 1 valid → fifo_wr=0 and req_ready=0 for those 3 cycles; on the first cycle fifo_full=0 the request issues, and rr_ptr is unchanged by the stall.
- Read steering: port 0 reads A, port 1 reads B, port 0 reads C; controller returns 0x11, 0x22, 0x33 on consecutive cycles → rsp_valid sequence 01, 10, 01, each one cycle after its strobe, with rsp_data 0x11, 0x22, 0x33.
- Tag full: TAG_DEPTH=8, issue 8 reads with no returns, then port 0 read and port 1 write both valid → only the write issues; one ctl_rdata_valid then lets the read issue the same cycle as the pop, and count stays 8.
- Orphan: ctl_rdata_valid with no outstanding reads → orphan_err=1 next cycle, rsp_valid=0; orphan_err stays 1 until reset_n=0.
- Reset mid-stream: assert reset_n=0 with 3 reads outstanding → all outputs and counters zero next cycle; a subsequent ctl_rdata_valid sets orphan_err.
